ps2_host_tx: RTL



---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_host_tx_if.sv | 11 +
 rtl/ps2_sync_edge.sv | 37 +++
 rtl/ps2_host_tx.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, well-known command bytes
// and frame geometry, used by both the host transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RELEASE,
    ST_XFER,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;
  localparam logic [7:0] PS2_BREAK        = 8'hF0;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  modport master (output tx_data, tx_start, input tx_busy, tx_done, tx_err);
  modport slave  (input tx_data, tx_start, output tx_busy, tx_done, tx_err);
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a falling-edge
// strobe on the synchronized clock; shared with the receive path.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta_reg, clk_sync_reg, clk_prev_reg;
  logic data_meta_reg, data_sync_reg;

  // Reset to the idle-high bus level so no edge is invented at reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_reg  <= 1'b1;
      clk_sync_reg  <= 1'b1;
      clk_prev_reg  <= 1'b1;
      data_meta_reg <= 1'b1;
      data_sync_reg <= 1'b1;
    end else begin
      clk_meta_reg  <= ps2_clk_in;
      clk_sync_reg  <= clk_meta_reg;
      clk_prev_reg  <= clk_sync_reg;
      data_meta_reg <= ps2_data_in;
      data_sync_reg <= data_meta_reg;
    end
  end

  assign clk_sync  = clk_sync_reg;
  assign data_sync = data_sync_reg;
  assign clk_fall  = clk_prev_reg & ~clk_sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts one byte out on device clock falls and checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TO_W           = 18
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam logic [TO_W-1:0] INHIBIT_LOAD = TO_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0] TIMEOUT_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      STOP_BIT     = 4'(PS2_FRAME_BITS - 2);

  ps2_tx_state_t   state_reg, state_next;
  logic [TO_W-1:0] cnt_reg, cnt_next;
  logic [3:0]      bitcnt_reg, bitcnt_next;
  logic [8:0]      frame_reg, frame_next;
  logic            clk_oe_reg, clk_oe_next;
  logic            data_oe_reg, data_oe_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;

  logic clk_sync, data_sync, clk_fall;
  logic cnt_zero, bus_idle;

  ps2_sync_edge u_sync (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync),
    .data_sync   (data_sync),
    .clk_fall    (clk_fall)
  );

  assign cnt_zero = (cnt_reg == '0);
  assign bus_idle = clk_sync & data_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bitcnt_reg  <= '0;
      frame_reg   <= '0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bitcnt_reg  <= bitcnt_next;
      frame_reg   <= frame_next;
      clk_oe_reg  <= clk_oe_next;
      data_oe_reg <= data_oe_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  // One down-counter serves both the inhibit delay and the per-edge timeout.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bitcnt_next = bitcnt_reg;
    frame_next  = frame_reg;
    case (state_reg)
      ST_IDLE: begin
        if (host.tx_start) begin
          frame_next = {odd_parity(host.tx_data), host.tx_data};
          cnt_next   = INHIBIT_LOAD;
          state_next = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_zero) state_next = ST_RELEASE;
        else          cnt_next   = cnt_reg - TO_W'(1);
      end
      ST_RELEASE: begin
        bitcnt_next = '0;
        cnt_next    = TIMEOUT_LOAD;
        state_next  = ST_XFER;
      end
      ST_XFER: begin
        if (clk_fall) begin
          bitcnt_next = bitcnt_reg + 4'd1;
          cnt_next    = TIMEOUT_LOAD;
          if (bitcnt_reg == STOP_BIT) state_next = ST_ACK;
        end else if (cnt_zero) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - TO_W'(1);
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          cnt_next   = TIMEOUT_LOAD;
          state_next = data_sync ? ST_IDLE : ST_WAIT_IDLE;
        end else if (cnt_zero) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - TO_W'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (bus_idle || cnt_zero) state_next = ST_IDLE;
        else                      cnt_next   = cnt_reg - TO_W'(1);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    clk_oe_next  = clk_oe_reg;
    data_oe_next = data_oe_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    case (state_reg)
      ST_IDLE:    if (host.tx_start) clk_oe_next = 1'b1;
      ST_INHIBIT: if (cnt_zero) data_oe_next = 1'b1;
      ST_RELEASE: clk_oe_next = 1'b0;
      ST_XFER: begin
        // A 1 bit releases the line, a 0 bit pulls it low; the stop bit is a 1.
        if (clk_fall)
          data_oe_next = (bitcnt_reg == STOP_BIT) ? 1'b0 : ~frame_reg[bitcnt_reg];
        else if (cnt_zero)
          err_next = 1'b1;
      end
      ST_ACK: begin
        if (clk_fall) err_next = data_sync;
        else          err_next = cnt_zero;
      end
      ST_WAIT_IDLE: begin
        if (bus_idle) done_next = 1'b1;
        else          err_next  = cnt_zero;
      end
      default: ;
    endcase
    if (state_reg != ST_IDLE && state_next == ST_IDLE) begin
      clk_oe_next  = 1'b0;
      data_oe_next = 1'b0;
    end
  end

  assign host.tx_busy = (state_reg != ST_IDLE);
  assign host.tx_done = done_reg;
  assign host.tx_err  = err_reg;
  assign ps2_clk_oe   = clk_oe_reg;
  assign ps2_data_oe  = data_oe_reg;

endmodule
